// File: rtl/pipe_stage_pkg.sv
// Shared types for the elastic inter-stage pipeline register.
// State encoding and occupancy width used by pipe_stage_reg.
package pipe_stage_pkg;

  localparam int OCC_W = 2;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_ONE,
    ST_TWO
  } stage_state_t;

  function automatic logic [OCC_W-1:0] occ_of(input stage_state_t st);
    logic [OCC_W-1:0] occ;
    occ = '0;
    case (st)
      ST_ONE:  occ = 2'd1;
      ST_TWO:  occ = 2'd2;
      default: occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// Generic DATA_W-wide pipeline stage with valid/ready handshake and flush.
// Define PIPE_STAGE_SKID_EN for the 2-entry skid build with a registered in_ready.
module pipe_stage_reg
  import pipe_stage_pkg::*;
#(
  parameter int unsigned       DATA_W  = 32,
  parameter logic [DATA_W-1:0] NOP_VAL = '0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [OCC_W-1:0]  occupancy
);

  stage_state_t      state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic              accept, consume;

  assign consume   = out_valid & out_ready;
  assign accept    = in_valid & in_ready;
  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = main_q;
  assign occupancy = occ_of(state_q);

`ifdef PIPE_STAGE_SKID_EN
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              rdy_q;

  // Ready is taken from a flop so out_ready never reaches in_ready combinationally.
  assign in_ready = rdy_q & ~flush & ~RST;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_EMPTY;
      main_q  <= NOP_VAL;
      skid_q  <= NOP_VAL;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      rdy_q   <= (state_d != ST_TWO);
    end
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = NOP_VAL;
      skid_d  = NOP_VAL;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d = ST_ONE;
            main_d  = in_data;
          end
        end
        ST_ONE: begin
          if (accept && consume) begin
            main_d = in_data;
          end else if (consume) begin
            state_d = ST_EMPTY;
            main_d  = NOP_VAL;
          end else if (accept) begin
            state_d = ST_TWO;
            skid_d  = in_data;
          end
        end
        ST_TWO: begin
          if (consume) begin
            state_d = ST_ONE;
            main_d  = skid_q;
            skid_d  = NOP_VAL;
          end
        end
        default: begin
          state_d = ST_EMPTY;
          main_d  = NOP_VAL;
          skid_d  = NOP_VAL;
        end
      endcase
    end
  end

`else
  // Without the skid entry, accept-without-consume in ONE cannot occur.
  assign in_ready = (~out_valid | out_ready) & ~flush & ~RST;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_EMPTY;
      main_q  <= NOP_VAL;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
    end
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = NOP_VAL;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d = ST_ONE;
            main_d  = in_data;
          end
        end
        ST_ONE: begin
          if (accept) begin
            main_d = in_data;
          end else if (consume) begin
            state_d = ST_EMPTY;
            main_d  = NOP_VAL;
          end
        end
        default: begin
          state_d = ST_EMPTY;
          main_d  = NOP_VAL;
        end
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed vector table, corner sequences
// and randomized traffic against a queue-based reference model.
module tb_pipe_stage_reg;

  logic        CLK = 1'b0;
  logic        RST;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  occupancy;

  int unsigned checks = 0;
  int unsigned errors = 0;

  pipe_stage_reg #(
    .DATA_W (32),
    .NOP_VAL(32'h0)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .occupancy(occupancy)
  );

  always #5 CLK = ~CLK;

  // Reference model: a bounded FIFO of held entries plus the ready flag seen upstream.
`ifdef PIPE_STAGE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif
  logic [31:0] q[$];
  logic [31:0] mcons[$];
  logic [31:0] dut_cons[$];
  bit          rdy_reg;
  int unsigned occ_max = 0;

  function automatic bit model_ready(input bit fl, input bit ordy);
    if (CAP == 2) return rdy_reg && !fl;
    return ((q.size() == 0) || ordy) && !fl;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step(input bit fl, input bit iv, input logic [31:0] d, input bit ordy,
                      input bit e_ov, input logic [31:0] e_od, input bit e_ir,
                      input logic [1:0] e_occ, input string nm);
    bit m_cons, m_acc;
    flush = fl; in_valid = iv; in_data = d; out_ready = ordy;
    @(negedge CLK);
    chk({nm, ".out_valid"}, {31'b0, out_valid}, {31'b0, e_ov});
    chk({nm, ".out_data"},  out_data, e_od);
    chk({nm, ".in_ready"},  {31'b0, in_ready}, {31'b0, e_ir});
    chk({nm, ".occupancy"}, {30'b0, occupancy}, {30'b0, e_occ});
    if (occupancy > occ_max) occ_max = occupancy;
    if (out_valid && out_ready) dut_cons.push_back(out_data);
    m_cons = (q.size() != 0) && ordy;
    m_acc  = iv && model_ready(fl, ordy);
    @(posedge CLK); #1;
    if (m_cons) mcons.push_back(q.pop_front());
    if (fl) q.delete();
    else if (m_acc) q.push_back(d);
    rdy_reg = (q.size() < CAP);
  endtask

  task automatic mstep(input bit fl, input bit iv, input logic [31:0] d, input bit ordy,
                       input string nm);
    step(fl, iv, d, ordy, q.size() != 0, (q.size() != 0) ? q[0] : 32'h0,
         model_ready(fl, ordy), 2'(q.size()), nm);
  endtask

  typedef struct {
    bit          fl;
    bit          iv;
    logic [31:0] d;
    bit          ordy;
    bit          ov;
    logic [31:0] od;
    bit          ir;
    logic [1:0]  occ;
  } vec_t;

  function automatic vec_t v(input bit fl, input bit iv, input logic [31:0] d, input bit ordy,
                             input bit ov, input logic [31:0] od, input bit ir,
                             input logic [1:0] occ);
    vec_t r;
    r.fl = fl; r.iv = iv; r.d = d; r.ordy = ordy;
    r.ov = ov; r.od = od; r.ir = ir; r.occ = occ;
    return r;
  endfunction

  vec_t vt[$];

  initial begin
    int unsigned n20;
    bit fl, iv, ordy;
    logic [31:0] d;

    // Streaming at full rate.
    vt.push_back(v(0, 1, 32'h1, 1, 0, 32'h0, 1, 0));
    vt.push_back(v(0, 1, 32'h2, 1, 1, 32'h1, 1, 1));
    vt.push_back(v(0, 1, 32'h3, 1, 1, 32'h2, 1, 1));
    vt.push_back(v(0, 0, 32'h0, 1, 1, 32'h3, 1, 1));
    vt.push_back(v(0, 0, 32'h0, 1, 0, 32'h0, 1, 0));
`ifdef PIPE_STAGE_SKID_EN
    // Backpressure fills the skid entry, then drains in order.
    vt.push_back(v(0, 1, 32'hA, 0, 0, 32'h0, 1, 0));
    vt.push_back(v(0, 1, 32'hB, 0, 1, 32'hA, 1, 1));
    vt.push_back(v(0, 1, 32'hC, 0, 1, 32'hA, 0, 2));
    vt.push_back(v(0, 1, 32'hC, 1, 1, 32'hA, 0, 2));
    vt.push_back(v(0, 1, 32'hC, 1, 1, 32'hB, 1, 1));
    vt.push_back(v(0, 0, 32'h0, 1, 1, 32'hC, 1, 1));
    vt.push_back(v(0, 0, 32'h0, 0, 0, 32'h0, 1, 0));
    // Flush with two held entries and a pending push.
    vt.push_back(v(0, 1, 32'h10, 0, 0, 32'h0,  1, 0));
    vt.push_back(v(0, 1, 32'h11, 0, 1, 32'h10, 1, 1));
    vt.push_back(v(1, 1, 32'h12, 0, 1, 32'h10, 0, 2));
    vt.push_back(v(0, 0, 32'h0,  0, 0, 32'h0,  1, 0));
`else
    // Backpressure blocks in_ready while the single entry is held.
    vt.push_back(v(0, 1, 32'hA, 0, 0, 32'h0, 1, 0));
    vt.push_back(v(0, 1, 32'hB, 0, 1, 32'hA, 0, 1));
    vt.push_back(v(0, 1, 32'hB, 1, 1, 32'hA, 1, 1));
    vt.push_back(v(0, 1, 32'hC, 0, 1, 32'hB, 0, 1));
    vt.push_back(v(0, 1, 32'hC, 1, 1, 32'hB, 1, 1));
    vt.push_back(v(0, 0, 32'h0, 1, 1, 32'hC, 1, 1));
    vt.push_back(v(0, 0, 32'h0, 0, 0, 32'h0, 1, 0));
    // Flush with a held entry and a pending push.
    vt.push_back(v(0, 1, 32'h10, 0, 0, 32'h0,  1, 0));
    vt.push_back(v(0, 1, 32'h11, 0, 1, 32'h10, 0, 1));
    vt.push_back(v(1, 1, 32'h12, 0, 1, 32'h10, 0, 1));
    vt.push_back(v(0, 0, 32'h0,  0, 0, 32'h0,  1, 0));
`endif
    // Flush coinciding with a consume of the head.
    vt.push_back(v(0, 1, 32'h20, 0, 0, 32'h0,  1, 0));
    vt.push_back(v(1, 0, 32'h0,  1, 1, 32'h20, 0, 1));
    vt.push_back(v(0, 0, 32'h0,  0, 0, 32'h0,  1, 0));

    // Reset state.
    RST = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    q.delete(); rdy_reg = 1'b0;
    #12;
    chk("rst.out_valid", {31'b0, out_valid}, 32'h0);
    chk("rst.out_data",  out_data, 32'h0);
    chk("rst.occupancy", {30'b0, occupancy}, 32'h0);
    chk("rst.in_ready",  {31'b0, in_ready}, 32'h0);
    RST = 1'b0;
    @(posedge CLK); #1;
    rdy_reg = 1'b1;
    chk("rst_rel.in_ready", {31'b0, in_ready}, 32'h1);

    foreach (vt[i])
      step(vt[i].fl, vt[i].iv, vt[i].d, vt[i].ordy, vt[i].ov, vt[i].od, vt[i].ir, vt[i].occ,
           $sformatf("vec%0d", i));

    n20 = 0;
    foreach (dut_cons[i]) if (dut_cons[i] == 32'h20) n20++;
    chk("flush_consume.count20", n20, 32'd1);

    // out_ready -> in_ready path within one cycle.
    mstep(0, 1, 32'h30, 0, "cr_push");
    in_valid = 1'b0; out_ready = 1'b0;
    #2;
`ifdef PIPE_STAGE_SKID_EN
    chk("cr.ready_lo", {31'b0, in_ready}, 32'h1);
`else
    chk("cr.ready_lo", {31'b0, in_ready}, 32'h0);
`endif
    out_ready = 1'b1;
    #1;
    chk("cr.ready_hi", {31'b0, in_ready}, 32'h1);
    mstep(0, 0, 32'h0, 1, "cr_pop");

    // Asynchronous reset with the stage full.
    mstep(0, 1, 32'h40, 0, "mr_fill0");
    mstep(0, 1, 32'h41, 0, "mr_fill1");
    chk("mr.pre_occ", {30'b0, occupancy}, CAP);
    #3;
    in_valid = 1'b0;
    RST = 1'b1;
    #1;
    chk("mr.out_valid", {31'b0, out_valid}, 32'h0);
    chk("mr.out_data",  out_data, 32'h0);
    chk("mr.occupancy", {30'b0, occupancy}, 32'h0);
    chk("mr.in_ready",  {31'b0, in_ready}, 32'h0);
    q.delete(); rdy_reg = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK); #1;
    rdy_reg = 1'b1;
    chk("mr_rel.in_ready", {31'b0, in_ready}, 32'h1);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      fl   = ($urandom_range(0, 19) == 0);
      iv   = ($urandom_range(0, 9) < 7);
      ordy = ($urandom_range(0, 9) < 6);
      d    = $urandom;
      mstep(fl, iv, d, ordy, $sformatf("rnd%0d", i));
    end
    mstep(0, 0, 32'h0, 1, "drain0");
    mstep(0, 0, 32'h0, 1, "drain1");
    mstep(0, 0, 32'h0, 1, "drain2");

    chk("fifo.len", dut_cons.size(), mcons.size());
    for (int i = 0; i < dut_cons.size() && i < mcons.size(); i++)
      chk($sformatf("fifo.elem%0d", i), dut_cons[i], mcons[i]);
    chk("occ.max_le_cap", {31'b0, (occ_max <= CAP)}, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
